// File: rtl/spi_slave_mode0_if.sv
// spi_slave_mode0_if: SPI pins and tx/rx byte streams of spi_slave_mode0.
//   sclk, cs_n, mosi          : SPI inputs from the master (asynchronous to clk)
//   miso, miso_oe             : SPI data to the master and its output enable
//   tx_data, tx_valid, tx_ready : next byte to transmit, valid/ready handshake
//   rx_data, rx_valid         : last received byte, one-clk update strobe
//   busy                      : slave is selected
//   tx_underrun               : sticky "empty at byte start" flag, only with SPI_SLAVE_UNDERRUN_EN
interface spi_slave_mode0_if;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
`ifdef SPI_SLAVE_UNDERRUN_EN
    logic       tx_underrun;
    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun
    );
    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun
    );
`else
    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, busy
    );
    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy
    );
`endif
endinterface

// File: rtl/spi_slave_mode0.sv
// spi_slave_mode0: 8-bit SPI mode-0 slave with a one-byte tx holding register.
//   clk   : system clock, all state on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : spi_slave_mode0_if.slave (SPI pins, tx handshake, rx strobe, busy)
//   Define SPI_SLAVE_UNDERRUN_EN to add the sticky bus.tx_underrun flag.
module spi_slave_mode0 (
    input  logic              clk,
    input  logic              rst_n,
    spi_slave_mode0_if.slave  bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t     state_q, state_d;
    logic [1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_d, cs_d;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic       active, byte_start, accept;
    logic [7:0] hold_data, tx_shift, rx_data_q;
    logic [6:0] rx_shift;
    logic       hold_full, rx_valid_q;
    logic [2:0] bit_cnt;

    assign sclk_rise = sclk_sync[1] & ~sclk_d;
    assign sclk_fall = ~sclk_sync[1] & sclk_d;
    assign cs_rise   = cs_sync[1] & ~cs_d;
    assign cs_fall   = ~cs_sync[1] & cs_d;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], bus.sclk};
            cs_sync   <= {cs_sync[0], bus.cs_n};
            mosi_sync <= {mosi_sync[0], bus.mosi};
            sclk_d    <= sclk_sync[1];
            cs_d      <= cs_sync[1];
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;

    // A byte starts on selection, or on the falling edge that closes a full
    // byte (bit counter already wrapped); a deselect in the same cycle wins.
    always_comb begin
        active     = (state_q == ACTIVE);
        state_d    = active ? (cs_rise ? IDLE : ACTIVE) : (cs_fall ? ACTIVE : IDLE);
        byte_start = active ? (sclk_fall & ~cs_rise & (bit_cnt == 3'd0)) : cs_fall;
        accept     = bus.tx_valid & ~hold_full;
    end

    // A byte accepted in the load cycle stays held: the load uses the old contents.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hold_data  <= 8'h00;
            hold_full  <= 1'b0;
            tx_shift   <= 8'h00;
            rx_shift   <= 7'h00;
            bit_cnt    <= 3'd0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (accept)
                hold_data <= bus.tx_data;
            hold_full <= accept | (hold_full & ~byte_start);
            if (byte_start)
                tx_shift <= hold_full ? hold_data : 8'h00;
            else if (active && sclk_fall)
                tx_shift <= {tx_shift[6:0], 1'b0};
            if (active && cs_rise)
                bit_cnt <= 3'd0;
            else if (active && sclk_rise) begin
                rx_shift <= {rx_shift[5:0], mosi_sync[1]};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_data_q  <= {rx_shift, mosi_sync[1]};
                    rx_valid_q <= 1'b1;
                end
            end
        end

    assign bus.miso     = active & tx_shift[7];
    assign bus.miso_oe  = active;
    assign bus.busy     = active;
    assign bus.tx_ready = ~hold_full;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_UNDERRUN_EN
    // Setting wins over clearing so an empty load at selection is still flagged.
    logic underrun_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            underrun_q <= 1'b0;
        else if (byte_start && !hold_full)
            underrun_q <= 1'b1;
        else if (!active && cs_fall)
            underrun_q <= 1'b0;
    assign bus.tx_underrun = underrun_q;
`endif
endmodule
